// File: rtl/jt900h_regs.sv
// jt900h_regs: TLCS-900H CPU register file.
// Twenty 32-bit registers: four banks of XWA/XBC/XDE/XHL plus XIX, XIY, XIZ
// and XSP. One write port and two read ports. All three ports address the
// file by byte, and each access is a byte, a word or a long.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   cen                 clock enable; all state holds while low
//   wr_w/wr_addr/wr_data    write width (one-hot b/w/l), byte address, data
//   rd0_*/rd1_*         read address and width in; registered data out
//   rfp_ld/rfp_din      load the bank pointer
//   rfp_inc/rfp_dec     INCF / DECF
//   rfp                 current bank pointer (registered)
module jt900h_regs #(
  parameter logic [31:0] XSP_RST = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [2:0]  wr_w,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [7:0]  rd0_addr,
  input  logic [2:0]  rd0_w,
  input  logic [7:0]  rd1_addr,
  input  logic [2:0]  rd1_w,
  output logic [31:0] rd0_data,
  output logic [31:0] rd1_data,
  input  logic        rfp_ld,
  input  logic [1:0]  rfp_din,
  input  logic        rfp_inc,
  input  logic        rfp_dec,
  output logic [1:0]  rfp
);

  localparam int NREGS = 20;

  // Width code: 0 none, 1 byte, 2 word, 3 long. Lower bits win when multi-hot.
  function automatic logic [1:0] dec_w(input logic [2:0] w);
    if (w[0])      dec_w = 2'd1;
    else if (w[1]) dec_w = 2'd2;
    else if (w[2]) dec_w = 2'd3;
    else           dec_w = 2'd0;
  endfunction

  // Returns {valid, index}. Index = bank*4 + long, or 16 + n for XIX..XSP.
  function automatic logic [5:0] dec_addr(input logic [7:0] a, input logic [1:0] p);
    logic [1:0] bank;
    bank     = p - 2'd1;
    dec_addr = 6'd0;
    if (a[7:6] == 2'b00)     dec_addr = {1'b1, 1'b0, a[5:4], a[3:2]};
    else if (a[7:4] == 4'hD) dec_addr = {1'b1, 1'b0, bank, a[3:2]};
    else if (a[7:4] == 4'hE) dec_addr = {1'b1, 1'b0, p, a[3:2]};
    else if (a[7:4] == 4'hF) dec_addr = {1'b1, 1'b1, 2'b00, a[3:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] ws, input logic [1:0] a);
    merge = old;
    case (ws)
      2'd1:    merge[{a, 3'b000} +: 8]      = d[7:0];
      2'd2:    merge[{a[1], 4'b0000} +: 16] = d[15:0];
      2'd3:    merge = d;
      default: merge = old;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] v, input logic [1:0] rs,
                                          input logic [1:0] a);
    case (rs)
      2'd1:    extract = {24'd0, v[{a, 3'b000} +: 8]};
      2'd2:    extract = {16'd0, v[{a[1], 4'b0000} +: 16]};
      2'd3:    extract = v;
      default: extract = 32'd0;
    endcase
  endfunction

  logic [31:0] regs [0:NREGS-1];

  logic [1:0]  wsel, r0sel, r1sel;
  logic [5:0]  wdec, r0dec, r1dec;
  logic        wr_en;
  logic [31:0] wr_old, wr_new, r0_long, r1_long, r0_val, r1_val;
  logic [1:0]  rfp_nxt;

  always_comb begin
    wsel   = dec_w(wr_w);
    r0sel  = dec_w(rd0_w);
    r1sel  = dec_w(rd1_w);
    // Decoding always uses the current pointer; a same-cycle rfp change
    // only takes effect on the next enabled cycle.
    wdec   = dec_addr(wr_addr, rfp);
    r0dec  = dec_addr(rd0_addr, rfp);
    r1dec  = dec_addr(rd1_addr, rfp);
    wr_en  = cen && (wsel != 2'd0) && wdec[5];
    wr_old = regs[wdec[4:0]];
    wr_new = merge(wr_old, wr_data, wsel, wr_addr[1:0]);
    // Write-through: a read of the long being written sees the merged value.
    r0_long = (wr_en && r0dec[4:0] == wdec[4:0]) ? wr_new : regs[r0dec[4:0]];
    r1_long = (wr_en && r1dec[4:0] == wdec[4:0]) ? wr_new : regs[r1dec[4:0]];
    r0_val  = r0dec[5] ? extract(r0_long, r0sel, rd0_addr[1:0]) : 32'd0;
    r1_val  = r1dec[5] ? extract(r1_long, r1sel, rd1_addr[1:0]) : 32'd0;
    if (rfp_ld)       rfp_nxt = rfp_din;
    else if (rfp_inc) rfp_nxt = rfp + 2'd1;
    else if (rfp_dec) rfp_nxt = rfp - 2'd1;
    else              rfp_nxt = rfp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == NREGS - 1) ? XSP_RST : 32'd0;
      rfp      <= 2'd0;
      rd0_data <= 32'd0;
      rd1_data <= 32'd0;
    end else if (cen) begin
      if (wr_en) regs[wdec[4:0]] <= wr_new;
      rd0_data <= r0_val;
      rd1_data <= r1_val;
      rfp      <= rfp_nxt;
    end
  end

endmodule

// File: tb/tb_jt900h_regs.sv
module tb_jt900h_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic [2:0]  wr_w = '0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [7:0]  rd0_addr = '0, rd1_addr = '0;
  logic [2:0]  rd0_w = '0, rd1_w = '0;
  logic [31:0] rd0_data, rd1_data;
  logic        rfp_ld = 1'b0, rfp_inc = 1'b0, rfp_dec = 1'b0;
  logic [1:0]  rfp_din = '0;
  logic [1:0]  rfp;

  jt900h_regs #(.XSP_RST(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_w(wr_w), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_addr(rd0_addr), .rd0_w(rd0_w), .rd1_addr(rd1_addr), .rd1_w(rd1_w),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .rfp_ld(rfp_ld), .rfp_din(rfp_din), .rfp_inc(rfp_inc), .rfp_dec(rfp_dec),
    .rfp(rfp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r0;
    logic [31:0] r1;
    logic [1:0]  p;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference model: register file as a flat byte array, 4 bytes per long.
  // Longs 0..15 are bank*4+reg, 16..19 are XIX, XIY, XIZ, XSP.
  logic [7:0]  mb [0:79];
  logic [1:0]  m_rfp;
  logic [31:0] m_rd0, m_rd1;

  function automatic int nbytes(input logic [2:0] w);
    if (w[0]) return 1;
    if (w[1]) return 2;
    if (w[2]) return 4;
    return 0;
  endfunction

  // First byte of the addressed access in mb, or -1 if unmapped.
  function automatic int byte_pos(input logic [7:0] a, input logic [1:0] p, input int n);
    int lng;
    int off;
    if (a < 8'h40)                        lng = int'(a[5:4]) * 4 + int'(a[3:2]);
    else if (a >= 8'hD0 && a <= 8'hDF)    lng = ((int'(p) + 3) % 4) * 4 + int'(a[3:2]);
    else if (a >= 8'hE0 && a <= 8'hEF)    lng = int'(p) * 4 + int'(a[3:2]);
    else if (a >= 8'hF0)                  lng = 16 + int'(a[3:2]);
    else return -1;
    off = int'(a[1:0]);
    if (n == 2) off = off - (off % 2);
    if (n == 4) off = 0;
    return lng * 4 + off;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a, input logic [2:0] w);
    int n;
    int b;
    logic [31:0] v;
    n = nbytes(w);
    b = byte_pos(a, m_rfp, n);
    v = 32'd0;
    if (n == 0 || b < 0) return 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[b + i]) << (8 * i));
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 80; i++) mb[i] = 8'h00;
    mb[76] = 8'h00; mb[77] = 8'h01; mb[78] = 8'h00; mb[79] = 8'h00;
    m_rfp = 2'd0;
    m_rd0 = 32'd0;
    m_rd1 = 32'd0;
  endtask

  task automatic m_cycle();
    int n;
    int b;
    logic [31:0] d;
    if (!cen) return;
    n = nbytes(wr_w);
    b = byte_pos(wr_addr, m_rfp, n);
    d = wr_data;
    if (n > 0 && b >= 0)
      for (int i = 0; i < n; i++) mb[b + i] = d[8*i +: 8];
    m_rd0 = m_read(rd0_addr, rd0_w);
    m_rd1 = m_read(rd1_addr, rd1_w);
    if (rfp_ld)       m_rfp = rfp_din;
    else if (rfp_inc) m_rfp = m_rfp + 2'd1;
    else if (rfp_dec) m_rfp = m_rfp - 2'd1;
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    e.r0 = m_rd0;
    e.r1 = m_rd1;
    e.p  = m_rfp;
    e.id = step_no;
    return e;
  endfunction

  // One clock: drive at negedge, predict, queue the expectation.
  // If use_lit, rd0 must also equal the hand-derived value lit0.
  task automatic step(input logic c, input logic [2:0] ww, input logic [7:0] wa,
                      input logic [31:0] wd, input logic [7:0] a0, input logic [2:0] w0,
                      input logic [7:0] a1, input logic [2:0] w1,
                      input logic ld, input logic [1:0] din, input logic inc, input logic dec,
                      input logic use_lit, input logic [31:0] lit0);
    exp_t e;
    @(negedge clk);
    cen = c; wr_w = ww; wr_addr = wa; wr_data = wd;
    rd0_addr = a0; rd0_w = w0; rd1_addr = a1; rd1_w = w1;
    rfp_ld = ld; rfp_din = din; rfp_inc = inc; rfp_dec = dec;
    step_no++;
    m_cycle();
    e = mk_exp();
    if (use_lit) e.r0 = lit0;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle(input logic keep_inputs);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    if (!keep_inputs) begin
      cen = 1'b0; wr_w = '0; rfp_ld = 1'b0; rfp_inc = 1'b0; rfp_dec = 1'b0;
    end
    step_no++;
    m_reset();
    e = mk_exp();
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b0;
    step_no++;
    e = mk_exp();
    exp_q.push_back(e);
  endtask

  // Monitor: every posedge, pop one expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rd0_data !== e.r0) begin
          errors++;
          $display("FAIL rd0 step %0d: got %08h expected %08h", e.id, rd0_data, e.r0);
        end
        checks++;
        if (rd1_data !== e.r1) begin
          errors++;
          $display("FAIL rd1 step %0d: got %08h expected %08h", e.id, rd1_data, e.r1);
        end
        checks++;
        if (rfp !== e.p) begin
          errors++;
          $display("FAIL rfp step %0d: got %0d expected %0d", e.id, rfp, e.p);
        end
      end
    end
  end

  function automatic logic [7:0] rnd_addr();
    case ($urandom_range(0, 4))
      0:       return 8'($urandom_range(8'h00, 8'h3F));
      1:       return 8'($urandom_range(8'hD0, 8'hDF));
      2:       return 8'($urandom_range(8'hE0, 8'hEF));
      3:       return 8'($urandom_range(8'hF0, 8'hFF));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    m_reset();
    rst = 1'b1;
    #12;
    reset_cycle(1'b0);

    // Reset values: XSP via 0xFC, bank rfp XWA via 0xE0.
    step(1, 3'b000, 8'h00, 0, 8'hFC, 3'b100, 8'hE0, 3'b100, 0, 0, 0, 0, 1, 32'h0000_0100);

    // Byte write merges into a long; word and byte reads of the same long.
    step(1, 3'b100, 8'hE0, 32'h1122_3344, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);
    step(1, 3'b001, 8'hE1, 32'h0000_00AA, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'hE0, 3'b100, 8'hE0, 3'b100, 0, 0, 0, 0, 1, 32'h1122_AA44);
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b010, 8'h01, 3'b010, 0, 0, 0, 0, 1, 32'h0000_AA44);
    step(1, 3'b000, 8'h00, 0, 8'h02, 3'b001, 8'h03, 3'b001, 0, 0, 0, 0, 1, 32'h0000_0022);

    // Banked addressing through rfp.
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 1, 2'd2, 0, 0, 0, 0);
    step(1, 3'b100, 8'hE4, 32'hCAFE_F00D, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'h24, 3'b100, 8'hE4, 3'b100, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 0, 1, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'hD4, 3'b100, 8'hD4, 3'b100, 0, 0, 0, 0, 1, 32'h0000_0000);
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 1, 2'd3, 0, 0, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'hD4, 3'b100, 8'hD4, 3'b100, 0, 0, 0, 0, 1, 32'hCAFE_F00D);

    // Write-through on XIX.
    step(1, 3'b100, 8'hF0, 32'h1234_5678, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);
    step(1, 3'b010, 8'hF2, 32'h0000_BEEF, 8'hF0, 3'b100, 8'hF3, 3'b001, 0, 0, 0, 0, 1, 32'hBEEF_5678);

    // rfp priority and wrap.
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 1, 2'd3, 0, 0, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 1, 0, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0, 1, 1, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'h00, 3'b000, 8'h00, 3'b000, 1, 2'd2, 1, 0, 0, 0);
    // Decode with the old rfp while it changes: write 0xE8 lands in bank 2.
    step(1, 3'b100, 8'hE8, 32'h5A5A_0001, 8'hE8, 3'b100, 8'h28, 3'b100, 0, 0, 1, 0, 1, 32'h5A5A_0001);
    step(1, 3'b000, 8'h00, 0, 8'h28, 3'b100, 8'hE8, 3'b100, 0, 0, 0, 0, 1, 32'h5A5A_0001);

    // cen low holds everything.
    step(1, 3'b000, 8'h00, 0, 8'h10, 3'b100, 8'hFC, 3'b100, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 3'b001, 8'h10, 32'hFFFF_FFFF, 8'hF0, 3'b100, 8'hE0, 3'b100, 0, 0, 1, 0, 0, 0);
    step(1, 3'b000, 8'h00, 0, 8'h10, 3'b100, 8'hFC, 3'b100, 0, 0, 0, 0, 1, 32'h0000_0000);
    // Unmapped address.
    step(1, 3'b100, 8'h50, 32'hDEAD_BEEF, 8'h50, 3'b100, 8'h50, 3'b001, 0, 0, 0, 0, 1, 32'h0000_0000);
    // Multi-hot width: byte wins.
    step(1, 3'b111, 8'h31, 32'h7766_5544, 8'h30, 3'b110, 8'h31, 3'b011, 0, 0, 0, 0, 1, 32'h0000_4400);

    // Reset in the middle of a write and rfp change.
    step(1, 3'b100, 8'hF4, 32'h0BAD_CAFE, 8'hF4, 3'b100, 8'h00, 3'b000, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    cen = 1'b1; wr_w = 3'b100; wr_addr = 8'hF4; wr_data = 32'h1111_2222; rfp_inc = 1'b1;
    reset_cycle(1'b1);
    step(1, 3'b000, 8'h00, 0, 8'hF4, 3'b100, 8'hFC, 3'b100, 0, 0, 0, 0, 1, 32'h0000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic c;
      logic [2:0] ww;
      c  = ($urandom_range(0, 9) != 0);
      ww = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      step(c, ww, rnd_addr(), $urandom, rnd_addr(), 3'($urandom), rnd_addr(), 3'($urandom),
           ($urandom_range(0, 9) == 0), 2'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0, 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt900h_regs.md
JT900H_REGS -- requirements
Module: jt900h_regs

Interface
REQ-001 Parameter XSP_RST, default 32'h0000_0100, reset value of XSP.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 cen  input  1  clock enable; no state or output changes when low.
REQ-005 wr_w  input  3  write width, one-hot: [0] byte, [1] word, [2] long; 0 = no write (driven by ALU alu_we).
REQ-006 wr_addr  input  8  byte-granular register address of write.
REQ-007 wr_data  input  32  write data, LSB-aligned (driven by ALU dout).
REQ-008 rd0_addr, rd1_addr  input  8 each  read-port register addresses.
REQ-009 rd0_w, rd1_w  input  3 each  read widths, same encoding as wr_w.
REQ-010 rd0_data, rd1_data  output  32 each  registered read results (ALU op0/op1 sources).
REQ-011 rfp_ld  input  1  load register-file pointer from rfp_din.
REQ-012 rfp_din  input  2  value for rfp_ld.
REQ-013 rfp_inc, rfp_dec  input  1 each  INCF/DECF requests.
REQ-014 rfp  output  2  current bank pointer.

Function
REQ-015 Storage: 4 banks x 4 longs (XWA, XBC, XDE, XHL) plus XIX, XIY, XIZ, XSP; 20 x 32-bit.
REQ-016 Address map: 0x00-0x3F bank (addr[5:4]), long addr[3:2]; 0xD0-0xDF bank (rfp-1) mod 4; 0xE0-0xEF bank rfp; 0xF0-0xFF XIX/XIY/XIZ/XSP by addr[3:2].
REQ-017 Unmapped addresses (0x40-0xCF): writes ignored, reads return 0.
REQ-018 Width decode priority when multi-hot: w[0] over w[1] over w[2]; w==0 means no access.
REQ-019 Byte write: only byte addr[1:0] of target long updated with wr_data[7:0].
REQ-020 Word write: addr[0] ignored; half addr[1] updated with wr_data[15:0]; other half unchanged.
REQ-021 Long write: addr[1:0] ignored; full long replaced with wr_data.
REQ-022 Reads mirror writes: byte at addr, word at addr[1], long at addr[3:2]; result zero-extended to 32 bits; rd_w==0 returns 0.
REQ-023 Read latency: rdN_data valid one cen-cycle after address/width presented; rdN_data holds while cen low.
REQ-024 Write-through bypass: read and write to same long in same cen-cycle returns post-write contents, with unwritten bytes from old contents.
REQ-025 Both read ports independent; identical addresses return identical data.
REQ-026 RFP update priority: rfp_ld > rfp_inc > rfp_dec; inc wraps 3->0, dec wraps 0->3.
REQ-027 Same-cycle write/read to 0xD0-0xEF and RFP change: address decoding uses pre-update rfp; new rfp applies from next cen-cycle.
REQ-028 rfp output is the registered pointer, no combinational path from rfp_* inputs.

Reset
REQ-029 On rst: all bank registers, XIX, XIY, XIZ = 0; XSP = XSP_RST; rfp = 0; rd0_data = rd1_data = 0.
REQ-030 rst asserted mid-operation overrides any in-flight write, RFP change, or read; first post-reset access sees reset values.

Verification
REQ-031 Reset, read rd0_addr=0xFC w=100 -> rd0_data=0x00000100; rd1_addr=0xE0 w=100 -> 0.
REQ-032 Long write 0xE0=0x11223344, byte write 0xE1=0xAA, then read 0xE0 long -> 0x1122AA44; read 0x00 word -> 0x0000AA44; read 0x02 byte -> 0x22.
REQ-033 rfp_ld=2, long write 0xE4=0xCAFEF00D; read 0x24 long -> 0xCAFEF00D; rfp_dec then read 0xD4 long -> 0; rfp_ld=3 then read 0xD4 -> 0xCAFEF00D.
REQ-034 Same cycle: word write 0xF2=0xBEEF to XIX (prior 0x12345678) and rd0 long 0xF0 -> next cycle rd0_data=0xBEEF5678.
REQ-035 rfp=3 plus rfp_inc -> rfp=0; rfp=0 plus rfp_dec together with rfp_inc -> rfp=1; rfp_ld=2 with rfp_inc -> rfp=2.
REQ-036 cen low for 3 cycles with wr_w=001 to 0x10 and rfp_inc -> no register, rfp, or rd_data change; write address 0x50 -> read 0x50 returns 0.
